// File: rtl/noun_mem_responder.sv
// Responder end of the traversal engine's memory request/acknowledge interface.
// Owns the noun RAM and services GET/SET/ALLOC requests through a one-deep pending slot.
module noun_mem_responder #(
    parameter int unsigned ADDR_WIDTH = 11,
    parameter int unsigned DATA_WIDTH = 64,
    parameter int unsigned FREE_BASE  = 1024
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  mem_execute,
    input  logic [1:0]            mem_func,
    input  logic [ADDR_WIDTH-1:0] address1,
    input  logic [ADDR_WIDTH-1:0] address2,
    input  logic [DATA_WIDTH-1:0] write_data,
    output logic                  mem_ready,
    output logic [DATA_WIDTH-1:0] read_data1,
    output logic [DATA_WIDTH-1:0] read_data2,
    output logic [ADDR_WIDTH-1:0] free_addr,
    output logic                  init_done,
    output logic [7:0]            error
);

    localparam logic [ADDR_WIDTH-1:0] Nil = '1;

    localparam logic [1:0] FuncIdle  = 2'd0;
    localparam logic [1:0] FuncGet   = 2'd1;
    localparam logic [1:0] FuncSet   = 2'd2;
    localparam logic [1:0] FuncAlloc = 2'd3;

    localparam logic [1:0] StInit   = 2'd0;
    localparam logic [1:0] StIdle   = 2'd1;
    localparam logic [1:0] StAccess = 2'd2;
    localparam logic [1:0] StResp   = 2'd3;

    localparam logic [7:0] ErrNilAddr  = 8'h01;
    localparam logic [7:0] ErrHeapFull = 8'h02;
    localparam logic [7:0] ErrOverrun  = 8'h03;

    logic [DATA_WIDTH-1:0] mem_q [2**ADDR_WIDTH];

    logic [1:0]            state_q, state_d;
    logic [ADDR_WIDTH-1:0] init_cnt_q, init_cnt_d;
    logic                  init_done_q, init_done_d;

    logic                  pend_valid_q, pend_valid_d;
    logic [1:0]            pend_func_q, pend_func_d;
    logic [ADDR_WIDTH-1:0] pend_a1_q, pend_a1_d;
    logic [ADDR_WIDTH-1:0] pend_a2_q, pend_a2_d;
    logic [DATA_WIDTH-1:0] pend_wd_q, pend_wd_d;

    logic [1:0]            cur_func_q, cur_func_d;
    logic [ADDR_WIDTH-1:0] cur_a1_q, cur_a1_d;
    logic [ADDR_WIDTH-1:0] cur_a2_q, cur_a2_d;
    logic [DATA_WIDTH-1:0] cur_wd_q, cur_wd_d;

    logic                  mem_ready_q, mem_ready_d;
    logic [DATA_WIDTH-1:0] rd1_q, rd1_d;
    logic [DATA_WIDTH-1:0] rd2_q, rd2_d;
    logic [ADDR_WIDTH-1:0] free_q, free_d;
    logic [7:0]            error_q, error_d;

    logic                  mem_we;
    logic [ADDR_WIDTH-1:0] mem_waddr;
    logic [DATA_WIDTH-1:0] mem_wdata;

    logic                  req;
    logic                  take_pend;
    logic                  take_req;
    logic                  a1_nil;
    logic                  a2_nil;
    logic [7:0]            acc_code;
    logic [7:0]            drop_code;

    assign req    = mem_execute && (mem_func != FuncIdle);
    assign a1_nil = (cur_a1_q == Nil);
    assign a2_nil = (cur_a2_q == Nil);

    always_comb begin
        state_d      = state_q;
        init_cnt_d   = init_cnt_q;
        init_done_d  = init_done_q;
        pend_valid_d = pend_valid_q;
        pend_func_d  = pend_func_q;
        pend_a1_d    = pend_a1_q;
        pend_a2_d    = pend_a2_q;
        pend_wd_d    = pend_wd_q;
        cur_func_d   = cur_func_q;
        cur_a1_d     = cur_a1_q;
        cur_a2_d     = cur_a2_q;
        cur_wd_d     = cur_wd_q;
        mem_ready_d  = 1'b0;
        rd1_d        = rd1_q;
        rd2_d        = rd2_q;
        free_d       = free_q;
        error_d      = error_q;
        mem_we       = 1'b0;
        mem_waddr    = '0;
        mem_wdata    = '0;
        take_pend    = 1'b0;
        take_req     = 1'b0;
        acc_code     = '0;
        drop_code    = '0;

        case (state_q)
            StInit: begin
                mem_we     = 1'b1;
                mem_waddr  = init_cnt_q;
                init_cnt_d = init_cnt_q + 1'b1;
                if (init_cnt_q == Nil) begin
                    init_done_d = 1'b1;
                    state_d     = StIdle;
                end
            end
            // RESP behaves like IDLE for dispatch so back-to-back requests skip a cycle.
            StIdle, StResp: begin
                if (pend_valid_q) begin
                    take_pend = 1'b1;
                    state_d   = StAccess;
                end else if (req) begin
                    take_req = 1'b1;
                    state_d  = StAccess;
                end else begin
                    state_d = StIdle;
                end
            end
            StAccess: begin
                state_d     = StResp;
                mem_ready_d = 1'b1;
                case (cur_func_q)
                    FuncGet: begin
                        rd1_d = a1_nil ? '0 : mem_q[cur_a1_q];
                        rd2_d = a2_nil ? '0 : mem_q[cur_a2_q];
                        if (a1_nil || a2_nil) begin
                            acc_code = ErrNilAddr;
                        end
                    end
                    FuncSet: begin
                        if (a1_nil) begin
                            acc_code = ErrNilAddr;
                        end else begin
                            mem_we    = 1'b1;
                            mem_waddr = cur_a1_q;
                            mem_wdata = cur_wd_q;
                        end
                    end
                    FuncAlloc: begin
                        rd1_d = DATA_WIDTH'(free_q);
                        rd2_d = '0;
                        if (free_q == Nil) begin
                            acc_code = ErrHeapFull;
                        end else begin
                            mem_we    = 1'b1;
                            mem_waddr = free_q;
                            mem_wdata = cur_wd_q;
                            free_d    = free_q + 1'b1;
                        end
                    end
                    default: ;
                endcase
            end
            default: state_d = StInit;
        endcase

        if (take_pend) begin
            cur_func_d   = pend_func_q;
            cur_a1_d     = pend_a1_q;
            cur_a2_d     = pend_a2_q;
            cur_wd_d     = pend_wd_q;
            pend_valid_d = 1'b0;
        end else if (take_req) begin
            cur_func_d = mem_func;
            cur_a1_d   = address1;
            cur_a2_d   = address2;
            cur_wd_d   = write_data;
        end

        // A request not dispatched directly goes to the slot, or is dropped if it is occupied.
        if (req && !take_req) begin
            if (pend_valid_q) begin
                drop_code = ErrOverrun;
            end else begin
                pend_valid_d = 1'b1;
                pend_func_d  = mem_func;
                pend_a1_d    = address1;
                pend_a2_d    = address2;
                pend_wd_d    = write_data;
            end
        end

        if (error_q == '0) begin
            error_d = (acc_code != '0) ? acc_code : drop_code;
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q      <= StInit;
            init_cnt_q   <= '0;
            init_done_q  <= 1'b0;
            pend_valid_q <= 1'b0;
            pend_func_q  <= FuncIdle;
            pend_a1_q    <= '0;
            pend_a2_q    <= '0;
            pend_wd_q    <= '0;
            cur_func_q   <= FuncIdle;
            cur_a1_q     <= '0;
            cur_a2_q     <= '0;
            cur_wd_q     <= '0;
            mem_ready_q  <= 1'b0;
            rd1_q        <= '0;
            rd2_q        <= '0;
            free_q       <= ADDR_WIDTH'(FREE_BASE);
            error_q      <= '0;
        end else begin
            state_q      <= state_d;
            init_cnt_q   <= init_cnt_d;
            init_done_q  <= init_done_d;
            pend_valid_q <= pend_valid_d;
            pend_func_q  <= pend_func_d;
            pend_a1_q    <= pend_a1_d;
            pend_a2_q    <= pend_a2_d;
            pend_wd_q    <= pend_wd_d;
            cur_func_q   <= cur_func_d;
            cur_a1_q     <= cur_a1_d;
            cur_a2_q     <= cur_a2_d;
            cur_wd_q     <= cur_wd_d;
            mem_ready_q  <= mem_ready_d;
            rd1_q        <= rd1_d;
            rd2_q        <= rd2_d;
            free_q       <= free_d;
            error_q      <= error_d;
        end
    end

    // RAM contents are cleared by the INIT sweep, not by reset.
    always_ff @(posedge clk) begin
        if (mem_we) begin
            mem_q[mem_waddr] <= mem_wdata;
        end
    end

    assign mem_ready  = mem_ready_q;
    assign read_data1 = rd1_q;
    assign read_data2 = rd2_q;
    assign free_addr  = free_q;
    assign init_done  = init_done_q;
    assign error      = error_q;

endmodule

// File: tb/tb_noun_mem_responder.sv
// Self-checking bench for noun_mem_responder: directed scenarios plus randomized traffic
// checked against an in-order behavioural model of the noun memory.
module tb_noun_mem_responder;

    localparam logic [10:0] NIL     = 11'h7ff;
    localparam logic [1:0]  F_GET   = 2'd1;
    localparam logic [1:0]  F_SET   = 2'd2;
    localparam logic [1:0]  F_ALLOC = 2'd3;

    logic        clk         = 1'b0;
    logic        rst         = 1'b1;
    logic        mem_execute = 1'b0;
    logic [1:0]  mem_func    = 2'd0;
    logic [10:0] address1    = '0;
    logic [10:0] address2    = '0;
    logic [63:0] write_data  = '0;
    logic        mem_ready;
    logic [63:0] read_data1;
    logic [63:0] read_data2;
    logic [10:0] free_addr;
    logic        init_done;
    logic [7:0]  error;

    noun_mem_responder #(
        .ADDR_WIDTH(11),
        .DATA_WIDTH(64),
        .FREE_BASE (1024)
    ) dut (
        .clk        (clk),
        .rst        (rst),
        .mem_execute(mem_execute),
        .mem_func   (mem_func),
        .address1   (address1),
        .address2   (address2),
        .write_data (write_data),
        .mem_ready  (mem_ready),
        .read_data1 (read_data1),
        .read_data2 (read_data2),
        .free_addr  (free_addr),
        .init_done  (init_done),
        .error      (error)
    );

    always #5 clk = ~clk;

    int unsigned cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    int unsigned n_checks = 0;
    int unsigned n_fail   = 0;
    int unsigned issued   = 0;
    int unsigned done_cnt = 0;
    int unsigned strobe_cyc, ready_cyc, init_rise_cyc, rel_cyc;
    bit          prev_ready, prev_init;

    // Behavioural model: RAM image, allocator, sticky error and last returned read data.
    typedef struct {
        logic [63:0] rd1;
        logic [63:0] rd2;
        bit          ok1;
        bit          ok2;
        logic [10:0] free;
        logic [7:0]  err;
    } resp_t;

    logic [63:0] m_mem [2048];
    logic [10:0] m_free;
    logic [7:0]  m_err;
    logic [63:0] m_rd1, m_rd2;
    bit          m_ok1, m_ok2;
    resp_t       exp_q[$];

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    task automatic fail_now(input string name, input string what);
        n_checks++;
        n_fail++;
        $display("FAIL %s: %s (cycle %0d)", name, what, cyc);
    endtask

    function automatic void model_reset();
        for (int i = 0; i < 2048; i++) m_mem[i] = '0;
        m_free = 11'd1024;
        m_err  = 8'h00;
        m_rd1  = '0;
        m_rd2  = '0;
        m_ok1  = 1'b1;
        m_ok2  = 1'b1;
        exp_q.delete();
    endfunction

    function automatic void model_push(input logic [1:0] f, input logic [10:0] a1,
                                       input logic [10:0] a2, input logic [63:0] wd);
        resp_t       r;
        logic [7:0]  code = 8'h00;
        case (f)
            F_GET: begin
                m_rd1 = (a1 == NIL) ? 64'd0 : m_mem[a1];
                m_rd2 = (a2 == NIL) ? 64'd0 : m_mem[a2];
                m_ok1 = 1'b1;
                m_ok2 = 1'b1;
                if (a1 == NIL || a2 == NIL) code = 8'h01;
            end
            F_SET: begin
                if (a1 == NIL) code = 8'h01;
                else m_mem[a1] = wd;
            end
            F_ALLOC: begin
                if (m_free == NIL) begin
                    code  = 8'h02;
                    m_ok1 = 1'b0;
                    m_ok2 = 1'b0;
                end else begin
                    m_mem[m_free] = wd;
                    m_rd1  = 64'(m_free);
                    m_ok1  = 1'b1;
                    m_ok2  = 1'b0;
                    m_free = m_free + 11'd1;
                end
            end
            default: ;
        endcase
        if (m_err == 8'h00) m_err = code;
        r.rd1  = m_rd1;
        r.rd2  = m_rd2;
        r.ok1  = m_ok1;
        r.ok2  = m_ok2;
        r.free = m_free;
        r.err  = m_err;
        exp_q.push_back(r);
    endfunction

    // Per-cycle compare, run from sync() at every falling edge.
    task automatic monitor_step();
        resp_t r;
        if (!rst) begin
            prev_ready = 1'b0;
            prev_init  = 1'b0;
            done_cnt   = 0;
            return;
        end
        if (init_done && !prev_init) init_rise_cyc = cyc;
        prev_init = init_done;
        if (mem_ready) begin
            check("ready_not_consecutive", 64'(prev_ready), 64'd0);
            ready_cyc = cyc;
            done_cnt++;
            if (exp_q.size() == 0) begin
                fail_now("unexpected_ready", "mem_ready with no request outstanding");
            end else begin
                r = exp_q.pop_front();
                if (r.ok1) check("read_data1", read_data1, r.rd1);
                if (r.ok2) check("read_data2", read_data2, r.rd2);
                check("free_addr", 64'(free_addr), 64'(r.free));
                check("error", 64'(error), 64'(r.err));
            end
        end
        prev_ready = mem_ready;
    endtask

    task automatic sync();
        @(negedge clk);
        monitor_step();
        #1;
    endtask

    task automatic drive(input logic [1:0] f, input logic [10:0] a1, input logic [10:0] a2,
                         input logic [63:0] wd);
        mem_func    = f;
        address1    = a1;
        address2    = a2;
        write_data  = wd;
        mem_execute = 1'b1;
        sync();
        mem_execute = 1'b0;
        mem_func    = 2'd0;
    endtask

    // Strobe only when the request will be accepted: nothing in flight, or one in flight
    // that is not in its response cycle (so the pending slot is free).
    task automatic issue(input logic [1:0] f, input logic [10:0] a1, input logic [10:0] a2,
                         input logic [63:0] wd);
        int g  = 0;
        bit ok = 1'b0;
        while (!ok && g < 50) begin
            ok = ((issued - done_cnt) == 0) || ((issued - done_cnt) == 1 && !mem_ready);
            if (!ok) begin
                sync();
                g++;
            end
        end
        if (!ok) begin
            fail_now("issue_timeout", "responder never became ready for a request");
            return;
        end
        model_push(f, a1, a2, wd);
        issued++;
        strobe_cyc = cyc;
        drive(f, a1, a2, wd);
    endtask

    task automatic wait_idle();
        int g = 0;
        while (issued != done_cnt && g < 50) begin
            sync();
            g++;
        end
        if (issued != done_cnt) begin
            fail_now("wait_idle", $sformatf("%0d responses seen, %0d required", done_cnt, issued));
            done_cnt = issued;
            exp_q.delete();
        end
    endtask

    task automatic single(input logic [1:0] f, input logic [10:0] a1, input logic [10:0] a2,
                          input logic [63:0] wd);
        issue(f, a1, a2, wd);
        wait_idle();
        check("ready_latency", 64'(ready_cyc - strobe_cyc), 64'd2);
    endtask

    task automatic check_reset_values(input string tag);
        check({tag, "_mem_ready"}, 64'(mem_ready), 64'd0);
        check({tag, "_read_data1"}, read_data1, 64'd0);
        check({tag, "_read_data2"}, read_data2, 64'd0);
        check({tag, "_free_addr"}, 64'(free_addr), 64'd1024);
        check({tag, "_init_done"}, 64'(init_done), 64'd0);
        check({tag, "_error"}, 64'(error), 64'd0);
    endtask

    task automatic start_reset();
        rst         = 1'b0;
        mem_execute = 1'b0;
        mem_func    = 2'd0;
        #1;
        check_reset_values("reset");
        model_reset();
        issued = 0;
        repeat (3) sync();
        check_reset_values("reset_hold");
        rst     = 1'b1;
        rel_cyc = cyc;
    endtask

    task automatic wait_init();
        int g = 0;
        while (!init_done && g < 3000) begin
            sync();
            g++;
        end
        if (!init_done) fail_now("init_timeout", "init_done never rose");
        else check("init_latency", 64'(init_rise_cyc - rel_cyc), 64'd2048);
        check("free_after_init", 64'(free_addr), 64'd1024);
    endtask

    function automatic logic [10:0] rnd_addr();
        if (m_free > 11'd1024 && $urandom_range(0, 1) == 1)
            return 11'(32'd1024 + $urandom_range(0, 32'(m_free) - 32'd1025));
        return 11'($urandom_range(0, 31));
    endfunction

    initial begin
        #5_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog expired");
    end

    initial begin
        int unsigned f0;
        int unsigned r;
        #2;
        // Reset, INIT sweep, then the cleared RAM reads back zero.
        start_reset();
        wait_init();
        single(F_GET, 11'd5, 11'd6, 64'd0);
        check("get_cleared_rd1", read_data1, 64'd0);
        check("get_cleared_rd2", read_data2, 64'd0);

        single(F_SET, 11'd10, 11'd0, 64'hA5);
        single(F_GET, 11'd10, 11'd11, 64'd0);
        check("set_get_rd1", read_data1, 64'hA5);
        check("set_get_rd2", read_data2, 64'd0);

        single(F_ALLOC, 11'd0, 11'd0, 64'h1234);
        check("alloc1_addr", read_data1, 64'd1024);
        single(F_ALLOC, 11'd0, 11'd0, 64'h1234);
        check("alloc2_addr", read_data1, 64'd1025);
        check("alloc_free", 64'(free_addr), 64'd1026);
        single(F_GET, 11'd1024, 11'd1025, 64'd0);
        check("alloc_get_rd1", read_data1, 64'h1234);
        check("alloc_get_rd2", read_data2, 64'h1234);

        // Randomized traffic, back-to-back where the slot allows.
        for (int i = 0; i < 250; i++) begin
            r = $urandom_range(0, 9);
            if (r < 4) issue(F_GET, rnd_addr(), rnd_addr(), 64'd0);
            else if (r < 8) issue(F_SET, rnd_addr(), 11'd0, {$urandom, $urandom});
            else issue(F_ALLOC, 11'd0, 11'd0, {$urandom, $urandom});
            if ($urandom_range(0, 3) == 0) sync();
        end
        wait_idle();

        // NIL address: no write, error 01, read port returns zero.
        single(F_SET, NIL, 11'd0, 64'hDEAD_BEEF);
        check("nil_set_error", 64'(error), 64'h01);
        single(F_GET, NIL, 11'd10, 64'd0);
        check("nil_get_rd1", read_data1, 64'd0);

        // Reset during ACCESS: request lost, outputs back to reset values.
        issue(F_GET, 11'd10, 11'd11, 64'd0);
        check("in_access_no_ready", 64'(mem_ready), 64'd0);
        start_reset();
        wait_init();

        // Drive the allocator to saturation.
        f0 = n_fail;
        while (m_free != 11'd2046 && n_fail == f0) issue(F_ALLOC, 11'd0, 11'd0, {$urandom, 32'd7});
        wait_idle();
        single(F_ALLOC, 11'd0, 11'd0, 64'h55);
        check("alloc_last_addr", read_data1, 64'd2046);
        check("alloc_last_free", 64'(free_addr), 64'd2047);
        single(F_ALLOC, 11'd0, 11'd0, 64'h66);
        check("alloc_full_error", 64'(error), 64'h02);
        check("alloc_full_free", 64'(free_addr), 64'd2047);

        // Two strobes during INIT: first is held and serviced, second overruns the slot.
        start_reset();
        sync();
        sync();
        m_err = 8'h03;
        model_push(F_GET, 11'd10, 11'd11, 64'd0);
        issued++;
        drive(F_GET, 11'd10, 11'd11, 64'd0);
        drive(F_GET, 11'd12, 11'd13, 64'd0);
        wait_init();
        wait_idle();
        check("init_queued_latency", 64'(ready_cyc - init_rise_cyc), 64'd2);
        check("overrun_error", 64'(error), 64'h03);
        repeat (4) sync();

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
